// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port RAM between the fetch port and the load/store port.
// Requests are serialised as IDLE -> ACC_IF | ACC_MEM -> DONE -> IDLE, with alignment checks and a ready timeout.
module mem_port_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [1:0]        mem_size,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_done,
   output logic              ram_en,
   output logic              ram_we,
   output logic [1:0]        ram_size,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   input  logic              ram_ready,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              align_err,
   output logic              timeout_err
);

   typedef enum logic [1:0] {S_IDLE, S_ACC_IF, S_ACC_MEM, S_DONE} state_t;

   localparam logic [7:0] LP_LAST = 8'(MAX_WAIT - 1);

   state_t     r_state, w_nxt;
   logic [7:0] r_wait;
   logic [1:0] r_fair;
   logic       r_gnt_mem;
   logic       r_align;
   logic       w_misalign, w_gnt_if, w_gnt_mem, w_timeout;

   always_comb begin
      w_misalign = 1'b0;
      case (mem_size)
         2'b00:   w_misalign = 1'b0;
         2'b01:   w_misalign = mem_addr[0];
         default: w_misalign = |mem_addr[1:0];
      endcase
      // Loads/stores are older than the fetch, except fetch gets one turn after two data grants.
      w_gnt_if  = if_req & (~mem_req | (r_fair == 2'd2));
      w_gnt_mem = mem_req & ~w_gnt_if;
      w_timeout = (r_wait == LP_LAST) & ~ram_ready;
      w_nxt     = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_gnt_if)       w_nxt = S_ACC_IF;
            else if (w_gnt_mem) w_nxt = w_misalign ? S_DONE : S_ACC_MEM;
         end
         S_ACC_IF, S_ACC_MEM: begin
            if (ram_ready || w_timeout) w_nxt = S_DONE;
         end
         default: w_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_wait      <= '0;
         r_fair      <= '0;
         r_gnt_mem   <= 1'b0;
         r_align     <= 1'b0;
         if_rdata    <= '0;
         mem_rdata   <= '0;
         ram_en      <= 1'b0;
         ram_we      <= 1'b0;
         ram_size    <= '0;
         ram_addr    <= '0;
         ram_wdata   <= '0;
         timeout_err <= 1'b0;
      end else begin
         r_state <= w_nxt;
         case (r_state)
            S_IDLE: begin
               r_wait <= '0;
               if (w_gnt_if) begin
                  r_fair    <= '0;
                  r_gnt_mem <= 1'b0;
                  r_align   <= 1'b0;
                  ram_en    <= 1'b1;
                  ram_we    <= 1'b0;
                  ram_size  <= 2'b10;
                  ram_addr  <= if_addr;
                  ram_wdata <= '0;
               end else if (w_gnt_mem) begin
                  // Fetch can only be waiting here while r_fair < 2, so this never overflows.
                  r_fair    <= if_req ? r_fair + 2'd1 : 2'd0;
                  r_gnt_mem <= 1'b1;
                  r_align   <= w_misalign;
                  if (w_misalign) begin
                     mem_rdata <= '0;
                  end else begin
                     ram_en    <= 1'b1;
                     ram_we    <= mem_we;
                     ram_size  <= (mem_size == 2'b11) ? 2'b10 : mem_size;
                     ram_addr  <= mem_addr;
                     ram_wdata <= mem_wdata;
                  end
               end
            end
            S_ACC_IF, S_ACC_MEM: begin
               if (ram_ready || w_timeout) begin
                  if (r_state == S_ACC_IF)
                     if_rdata <= ram_ready ? ram_rdata : '0;
                  else
                     mem_rdata <= (ram_ready && !ram_we) ? ram_rdata : '0;
                  if (!ram_ready) timeout_err <= 1'b1;
                  ram_en    <= 1'b0;
                  ram_we    <= 1'b0;
                  ram_size  <= '0;
                  ram_addr  <= '0;
                  ram_wdata <= '0;
               end else begin
                  r_wait <= r_wait + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign if_done   = (r_state == S_DONE) & ~r_gnt_mem;
   assign mem_done  = (r_state == S_DONE) &  r_gnt_mem;
   assign align_err = mem_done & r_align;
   assign stall_if  = if_req & ~if_done;
   assign stall_mem = mem_req & ~mem_done;

endmodule
